// File: rtl/npu_layer_sequencer.sv
// Job sequencer for the 8x8 NPU MAC: loads 16 weight words and 2 input words
// into the NPU window, reads back 8 row results, optionally applies ReLU, stores them.
`timescale 1ns/1ps
module npu_layer_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] cfg_w_addr,
  input  logic [31:0] cfg_x_addr,
  input  logic [31:0] cfg_y_addr,
  input  logic        cfg_relu,
  output logic        busy,
  output logic        done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        npu_write,
  output logic [6:0]  npu_byte_off,
  output logic [31:0] npu_wdata,
  output logic        npu_read,
  output logic [6:0]  npu_read_off,
  input  logic [31:0] npu_rdata
);

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE, LD_REQ, LD_WAIT, NPU_WR, RD_ISSUE, RD_CAP, ST_REQ, DONE
  } state_t;

  state_t state_q, state_d;
  logic [4:0] k_q, k_d;
  logic [2:0] r_q, r_d;
  logic [DATA_W-1:0] w_base_q, w_base_d, x_base_q, x_base_d, y_base_q, y_base_d;
  logic relu_q, relu_d;

  logic        busy_q, busy_d, done_q, done_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        npu_write_q, npu_write_d, npu_read_q, npu_read_d;
  logic [6:0]  npu_byte_off_q, npu_byte_off_d, npu_read_off_q, npu_read_off_d;
  logic [31:0] npu_wdata_q, npu_wdata_d;

  logic signed [DATA_W-1:0] npu_res;
  assign npu_res = npu_rdata;

  function automatic logic signed [DATA_W-1:0] relu_clamp(
    input logic signed [DATA_W-1:0] v,
    input logic                     en
  );
    return (en && (v < 0)) ? '0 : v;
  endfunction

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    r_d         = r_q;
    w_base_d    = w_base_q;
    x_base_d    = x_base_q;
    y_base_d    = y_base_q;
    relu_d      = relu_q;
    mem_wdata_d = mem_wdata_q;
    npu_wdata_d = npu_wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          w_base_d = cfg_w_addr & ~32'h3;
          x_base_d = cfg_x_addr & ~32'h3;
          y_base_d = cfg_y_addr & ~32'h3;
          relu_d   = cfg_relu;
          k_d      = '0;
          r_d      = '0;
          state_d  = LD_REQ;
        end
      end
      LD_REQ:   if (mem_gnt) state_d = LD_WAIT;
      LD_WAIT: begin
        if (mem_rvalid) begin
          npu_wdata_d = mem_rdata;
          state_d     = NPU_WR;
        end
      end
      NPU_WR: begin
        if (k_q == 5'd17) begin
          r_d     = '0;
          state_d = RD_ISSUE;
        end else begin
          k_d     = k_q + 5'd1;
          state_d = LD_REQ;
        end
      end
      RD_ISSUE: state_d = RD_CAP;
      RD_CAP: begin
        mem_wdata_d = relu_clamp(npu_res, relu_q);
        state_d     = ST_REQ;
      end
      ST_REQ: begin
        if (mem_gnt) begin
          if (r_q == 3'd7) begin
            state_d = DONE;
          end else begin
            r_d     = r_q + 3'd1;
            state_d = RD_ISSUE;
          end
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Outputs are decoded from next state so every port comes straight off a flop
    busy_d         = (state_d != IDLE) && (state_d != DONE);
    done_d         = (state_d == DONE);
    mem_req_d      = (state_d == LD_REQ) || (state_d == ST_REQ);
    mem_we_d       = (state_d == ST_REQ);
    npu_write_d    = (state_d == NPU_WR);
    npu_read_d     = (state_d == RD_ISSUE);
    mem_addr_d     = mem_addr_q;
    npu_byte_off_d = npu_byte_off_q;
    npu_read_off_d = npu_read_off_q;
    if (state_d == LD_REQ)
      mem_addr_d = (k_d[4] ? x_base_d : w_base_d) + {26'd0, k_d[3:0], 2'b00};
    if (state_d == ST_REQ)
      mem_addr_d = y_base_d + {27'd0, r_d, 2'b00};
    if (state_d == NPU_WR)
      npu_byte_off_d = {k_d, 2'b00};
    if (state_d == RD_ISSUE)
      npu_read_off_d = 7'h48 + {2'b00, r_d, 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      k_q            <= '0;
      r_q            <= '0;
      w_base_q       <= '0;
      x_base_q       <= '0;
      y_base_q       <= '0;
      relu_q         <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      npu_write_q    <= 1'b0;
      npu_byte_off_q <= '0;
      npu_wdata_q    <= '0;
      npu_read_q     <= 1'b0;
      npu_read_off_q <= '0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      r_q            <= r_d;
      w_base_q       <= w_base_d;
      x_base_q       <= x_base_d;
      y_base_q       <= y_base_d;
      relu_q         <= relu_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      npu_write_q    <= npu_write_d;
      npu_byte_off_q <= npu_byte_off_d;
      npu_wdata_q    <= npu_wdata_d;
      npu_read_q     <= npu_read_d;
      npu_read_off_q <= npu_read_off_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign npu_write    = npu_write_q;
  assign npu_byte_off = npu_byte_off_q;
  assign npu_wdata    = npu_wdata_q;
  assign npu_read     = npu_read_q;
  assign npu_read_off = npu_read_off_q;

endmodule
